// File: rtl/demux_rr_dispatcher_pkg.sv
// Shared types and helpers for the round-robin dispatcher.
// Holds the channel count, select width, FSM state type and the priority scan.
package demux_rr_dispatcher_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    // With skip set, the first enabled channel that is also ready wins.
    // Otherwise, the first enabled channel wins.
    // If no channel is enabled, ptr is returned. Callers gate on |en.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [SEL_W-1:0]  ptr,
        input logic [NUM_CH-1:0] en,
        input logic [NUM_CH-1:0] rdy,
        input logic              skip
    );
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick_r;
        logic [SEL_W-1:0] pick_e;
        logic             found_r;
        logic             found_e;
        idx     = ptr;
        pick_r  = ptr;
        pick_e  = ptr;
        found_r = 1'b0;
        found_e = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found_e && en[idx]) begin
                found_e = 1'b1;
                pick_e  = idx;
            end
            if (!found_r && en[idx] && rdy[idx]) begin
                found_r = 1'b1;
                pick_r  = idx;
            end
        end
        return (skip && found_r) ? pick_r : pick_e;
    endfunction

endpackage

// File: rtl/demux_rr_dispatcher_demux1to4.sv
// 1-to-4 demultiplexer: routes din to the output picked by sel.
// Ports: din (1b), sel (2b) -> dout (4b, at most one bit set).
module demux1to4
    import demux_rr_dispatcher_pkg::*;
(
    input  logic              din,
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] dout
);

    always_comb begin
        dout      = '0;
        dout[sel] = din;
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Round-robin dispatcher: one valid/ready input shared by four consumers.
// Ports: clk, rst, chan_en, in_valid/in_data/in_ready, out_valid/out_data/out_ready, sel, busy.
module demux_rr_dispatcher
    import demux_rr_dispatcher_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SKIP_BUSY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic [NUM_CH-1:0] out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [SEL_W-1:0]  sel,
    output logic              busy
);

    localparam logic SkipBusy = (SKIP_BUSY != 0);

    state_e           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] ptr_q;
    logic [WIDTH-1:0] data_q;

    logic             deliver;
    logic             accept;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] target;

    always_comb begin
        deliver  = (state_q == HOLD) && out_ready[sel_q];
        in_ready = ((state_q == IDLE) || deliver) && (|chan_en);
        accept   = in_valid && in_ready;
        // A word delivered this cycle moves the pointer first,
        // so a back-to-back word is scanned from the updated pointer.
        ptr_d    = deliver ? sel_q + SEL_W'(1) : ptr_q;
        target   = rr_pick(ptr_d, chan_en, out_ready, SkipBusy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (deliver) begin
                state_q <= IDLE;
            end
            if (accept) begin
                data_q  <= in_data;
                sel_q   <= target;
                state_q <= HOLD;
            end
        end
    end

    assign busy     = (state_q == HOLD);
    assign sel      = sel_q;
    assign out_data = data_q;

    demux1to4 u_demux (
        .din  (busy),
        .sel  (sel_q),
        .dout (out_valid)
    );

endmodule

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
Round-robin dispatcher that shares one input stream among four consumers by sequencing a 1-to-4 demux. It accepts words over a valid/ready handshake and holds each word in a one-entry output register. It steers valid to exactly one enabled consumer, then advances the rotation pointer. It sits in front of the demux1to4 datapath and generates its select.

Parameters:
WIDTH, 8, data word width in bits
SKIP_BUSY, 1, 1 = prefer a ready enabled channel when choosing a target; 0 = strict rotation over enabled channels

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
chan_en  input  4  per-channel enable mask (configuration)
in_valid  input  1  input word valid
in_data  input  WIDTH  input word
in_ready  output  1  dispatcher can accept in_data this cycle
out_valid  output  4  one-hot valid, demuxed by sel
out_data  output  WIDTH  held word, shared by all channels
out_ready  input  4  per-channel consumer ready
sel  output  2  current target channel; drives demux select
busy  output  1  output register holds an undelivered word

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; it is sampled only at the rising edge of clk.
- Reset values:
  - out_valid=0000, out_data=0, sel=00, busy=0.
  - Rotation pointer ptr=00, FSM=IDLE.
  - rst overrides any in-flight transfer; the held word is discarded without a handshake.
- FSM states:
  - IDLE: output register empty.
  - HOLD: output register full, waiting for out_ready[sel].
- in_ready is combinational: (IDLE or (HOLD and out_ready[sel])) and |chan_en. When chan_en=0000, in_ready=0 and nothing is accepted.
- Target choice, computed in the accept cycle:
  - Scan order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - SKIP_BUSY=1: pick the first channel in scan order that is enabled and has out_ready=1. If no such channel exists, pick the first enabled channel.
  - SKIP_BUSY=0: pick the first enabled channel.
- Accept (in_valid and in_ready): on the next edge, out_data<=in_data, sel<=target, FSM<=HOLD.
- Delivery:
  - In HOLD, out_valid = one-hot(sel); in IDLE, out_valid=0000.
  - A transfer completes when out_ready[sel]=1. On that edge, ptr<=sel+1 (mod 4, wraps from 11 to 00).
  - If there is no simultaneous accept, FSM<=IDLE.
- Simultaneous deliver and accept in HOLD: the new word loads in the same edge. The new target is computed from the updated ptr (sel+1). FSM stays in HOLD. This sustains 1 word/cycle.
- Latency: 1 cycle from accept to out_valid assertion.
- Backpressure: while in HOLD with out_ready[sel]=0, out_data, sel and out_valid stay stable and in_ready=0.
- chan_en changes while in HOLD: the held word stays bound to its sel (no retargeting) even if that channel is disabled. The new mask affects only the next target choice.
- out_ready on non-selected channels is ignored.
- busy = (FSM==HOLD).

Decomposition:
- Shared package: channel count constant (4), select width (2), FSM state typedef {IDLE, HOLD}.
- Sub-module: the existing demux1to4 is instantiated with din=busy and sel=sel, producing out_valid.
- The rotating-priority scan is a function in the package. No further sub-modules.

Test Plan:
- Reset, then chan_en=1111, out_ready=1111, words 0xA0,0xA1,0xA2,0xA3,0xA4 back-to-back -> sel=00,01,10,11,00; out_valid one-hot each cycle; in_ready stays 1; full throughput.
- chan_en=1010, SKIP_BUSY=0, out_ready=1111, 4 words -> sel sequence 01,11,01,11; channels 0 and 2 never valid.
- Accept 0x55 targeting ch0, hold out_ready[0]=0 for 5 cycles -> out_valid=0001, out_data=0x55 and sel stable; in_ready=0; delivery on the cycle out_ready[0] rises; ptr becomes 01.
- SKIP_BUSY=1, ptr=00, out_ready=0100, chan_en=1111 -> target sel=10; after delivery, next scan starts at 11.
- chan_en=0000 with in_valid=1 -> in_ready=0, busy=0, out_valid=0000. Then disable ch1 while HOLD on ch1 -> word 0x3C still delivered to ch1 on out_ready[1].
- rst asserted while HOLD with out_ready low -> next edge: out_valid=0000, sel=00, busy=0; in_ready=1 the following cycle with chan_en=1111.
